muldiv_unit: RTL and testbench

Parametrised multi-cycle multiply/divide unit with an internal HI/LO register pair, living in the EX stage beside the ALU. It accepts one operation per start pulse. Multiplies complete after a fixed pipeline latency; divides use an iterative radix-2 divider. It raises a one-cycle completion pulse and exposes HI/LO to the pipeline. It adds accumulate modes, pipeline flush, and defined divide-by-zero behaviour.

---
 rtl/muldiv_pkg.sv | 35 +++
 rtl/radix2_divider.sv | 89 ++++++++
 rtl/muldiv_unit.sv | 252 +++++++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types for the EX-stage multiply/divide unit: opcode and FSM state
// encodings plus the fixed divide-by-zero quotient pattern.
package muldiv_pkg;

    typedef enum logic [3:0] {
        MULT  = 4'd0,
        MULTU = 4'd1,
        DIV   = 4'd2,
        DIVU  = 4'd3,
        MADD  = 4'd4,
        MADDU = 4'd5,
        MSUB  = 4'd6,
        MSUBU = 4'd7,
        MTHI  = 4'd8,
        MTLO  = 4'd9
    } muldiv_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } muldiv_state_t;

    // Divide by zero returns an all-ones quotient; this is the replicated bit.
    localparam logic DIVZERO_Q_BIT = 1'b1;

    function automatic logic is_signed_op(input muldiv_op_t o);
        case (o)
            MULT, DIV, MADD, MSUB: is_signed_op = 1'b1;
            default:               is_signed_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/radix2_divider.sv
// Unsigned restoring divider, one quotient bit per cycle. The first step is
// taken in the start cycle so results are ready WIDTH-1 edges after start.
module radix2_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cancel,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             done
);
    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] quot_r;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] dvsr_r;
    logic [CW-1:0]    cnt_r;
    logic             done_r;

    logic [WIDTH-1:0] src_q_s;
    logic [WIDTH-1:0] src_r_s;
    logic [WIDTH-1:0] dvsr_s;
    logic [WIDTH-1:0] nq_s;
    logic [WIDTH-1:0] nr_s;
    logic [WIDTH:0]   shifted_s;
    logic [WIDTH:0]   trial_s;

    // Iteration source: fresh operands on start, otherwise the running partials
    always_comb begin
        if (start) begin
            src_q_s = dividend;
            src_r_s = '0;
            dvsr_s  = divisor;
        end else begin
            src_q_s = quot_r;
            src_r_s = rem_r;
            dvsr_s  = dvsr_r;
        end
    end

    // One restoring step; the trial MSB is the borrow since rem < divisor
    always_comb begin
        shifted_s = {src_r_s, src_q_s[WIDTH-1]};
        trial_s   = shifted_s - {1'b0, dvsr_s};
        if (trial_s[WIDTH]) begin
            nr_s = shifted_s[WIDTH-1:0];
            nq_s = {src_q_s[WIDTH-2:0], 1'b0};
        end else begin
            nr_s = trial_s[WIDTH-1:0];
            nq_s = {src_q_s[WIDTH-2:0], 1'b1};
        end
    end

    // Partial quotient/remainder registers and iteration counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quot_r <= '0;
            rem_r  <= '0;
            dvsr_r <= '0;
            cnt_r  <= '0;
            done_r <= 1'b0;
        end else if (cancel) begin
            cnt_r  <= '0;
            done_r <= 1'b0;
        end else if (start) begin
            quot_r <= nq_s;
            rem_r  <= nr_s;
            dvsr_r <= divisor;
            cnt_r  <= CW'(WIDTH - 1);
            done_r <= 1'b0;
        end else if (cnt_r != '0) begin
            quot_r <= nq_s;
            rem_r  <= nr_s;
            cnt_r  <= cnt_r - CW'(1);
            done_r <= (cnt_r == CW'(1));
        end else begin
            done_r <= 1'b0;
        end
    end

    assign quotient  = quot_r;
    assign remainder = rem_r;
    assign done      = done_r;

endmodule

// File: rtl/muldiv_unit.sv
// EX-stage multiply/divide unit with architectural HI/LO registers.
// Define MULDIV_MADD_EN to build the MADD/MADDU/MSUB/MSUBU accumulate path.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  muldiv_op_t       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             divzero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    muldiv_state_t      state_r;
    muldiv_state_t      state_nx_s;
    logic [CW-1:0]      cnt_r;
    logic [CW-1:0]      cnt_nx_s;
    muldiv_op_t         op_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic               dz_r;
    logic               latch_s;
    logic               pend_r;
    logic               pend_nx_s;
    muldiv_op_t         pend_op_r;
    logic [WIDTH-1:0]   pend_val_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;
    logic [WIDTH-1:0]   hi_nx_s;
    logic [WIDTH-1:0]   lo_nx_s;
    logic               done_r;
    logic               done_nx_s;
    logic               divzero_r;
    logic               divzero_nx_s;

    logic               mul_sgn_s;
    logic               prod_neg_s;
    logic [WIDTH-1:0]   mag_a_s;
    logic [WIDTH-1:0]   mag_b_s;
    logic [2*WIDTH-1:0] prod_mag_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0] mul_res_s;

    logic               div_sgn_s;
    logic               div_start_s;
    logic               div_done_s;
    logic               q_neg_s;
    logic               r_neg_s;
    logic [WIDTH-1:0]   dvd_mag_s;
    logic [WIDTH-1:0]   dvs_mag_s;
    logic [WIDTH-1:0]   quo_s;
    logic [WIDTH-1:0]   rem_s;
    logic [WIDTH-1:0]   fix_q_s;
    logic [WIDTH-1:0]   fix_r_s;

    // Signed multiply as a magnitude product followed by a two's-complement fix
    always_comb begin
        mul_sgn_s  = is_signed_op(op_r);
        mag_a_s    = (mul_sgn_s && a_r[WIDTH-1]) ? (-a_r) : a_r;
        mag_b_s    = (mul_sgn_s && b_r[WIDTH-1]) ? (-b_r) : b_r;
        prod_neg_s = mul_sgn_s && (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
        prod_mag_s = {{WIDTH{1'b0}}, mag_a_s} * {{WIDTH{1'b0}}, mag_b_s};
        prod_s     = prod_neg_s ? (-prod_mag_s) : prod_mag_s;
    end

`ifdef MULDIV_MADD_EN
    // Accumulate modes fold the product into {hi,lo}, wrapping at 2*WIDTH bits
    always_comb begin
        case (op_r)
            MADD, MADDU: mul_res_s = {hi_r, lo_r} + prod_s;
            MSUB, MSUBU: mul_res_s = {hi_r, lo_r} - prod_s;
            default:     mul_res_s = prod_s;
        endcase
    end
`else
    assign mul_res_s = prod_s;
`endif

    // Divider runs on magnitudes of the live operands; signs return in FIX
    always_comb begin
        div_sgn_s = (op == DIV);
        dvd_mag_s = (div_sgn_s && a[WIDTH-1]) ? (-a) : a;
        dvs_mag_s = (div_sgn_s && b[WIDTH-1]) ? (-b) : b;
        q_neg_s   = (op_r == DIV) && (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
        r_neg_s   = (op_r == DIV) && a_r[WIDTH-1];
        if (dz_r) begin
            fix_q_s = {WIDTH{DIVZERO_Q_BIT}};
            fix_r_s = a_r;
        end else begin
            fix_q_s = q_neg_s ? (-quo_s) : quo_s;
            fix_r_s = r_neg_s ? (-rem_s) : rem_s;
        end
    end

    radix2_divider #(
        .WIDTH(WIDTH)
    ) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start_s),
        .cancel    (flush),
        .dividend  (dvd_mag_s),
        .divisor   (dvs_mag_s),
        .quotient  (quo_s),
        .remainder (rem_s),
        .done      (div_done_s)
    );

    // Next-state, writeback and completion decode
    always_comb begin
        state_nx_s   = state_r;
        cnt_nx_s     = cnt_r;
        latch_s      = 1'b0;
        div_start_s  = 1'b0;
        pend_nx_s    = 1'b0;
        hi_nx_s      = hi_r;
        lo_nx_s      = lo_r;
        done_nx_s    = 1'b0;
        divzero_nx_s = 1'b0;
        if (flush) begin
            state_nx_s = ST_IDLE;
            cnt_nx_s   = '0;
        end else begin
            // Single-cycle ops (moves, NOPs) retire one edge after acceptance without busy
            if (pend_r) begin
                done_nx_s = 1'b1;
                if (pend_op_r == MTHI) begin
                    hi_nx_s = pend_val_r;
                end else if (pend_op_r == MTLO) begin
                    lo_nx_s = pend_val_r;
                end else begin
                    hi_nx_s = hi_r;
                end
            end else begin
                done_nx_s = 1'b0;
            end
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        case (op)
                            MULT, MULTU: begin
                                latch_s    = 1'b1;
                                state_nx_s = ST_MUL;
                                cnt_nx_s   = CW'(MUL_LAT - 1);
                            end
`ifdef MULDIV_MADD_EN
                            MADD, MADDU, MSUB, MSUBU: begin
                                latch_s    = 1'b1;
                                state_nx_s = ST_MUL;
                                cnt_nx_s   = CW'(MUL_LAT - 1);
                            end
`endif
                            DIV, DIVU: begin
                                latch_s     = 1'b1;
                                state_nx_s  = ST_DIV;
                                div_start_s = (b != '0);
                            end
                            default: pend_nx_s = 1'b1;
                        endcase
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end
                ST_MUL: begin
                    if (cnt_r == '0) begin
                        {hi_nx_s, lo_nx_s} = mul_res_s;
                        done_nx_s          = 1'b1;
                        state_nx_s         = ST_IDLE;
                    end else begin
                        cnt_nx_s = cnt_r - CW'(1);
                    end
                end
                ST_DIV: begin
                    if (dz_r || div_done_s) begin
                        state_nx_s = ST_FIX;
                    end else begin
                        state_nx_s = ST_DIV;
                    end
                end
                ST_FIX: begin
                    hi_nx_s      = fix_r_s;
                    lo_nx_s      = fix_q_s;
                    done_nx_s    = 1'b1;
                    divzero_nx_s = dz_r;
                    state_nx_s   = ST_IDLE;
                end
                default: state_nx_s = ST_IDLE;
            endcase
        end
    end

    // FSM state, completion flags and architectural HI/LO
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= '0;
            pend_r    <= 1'b0;
            hi_r      <= '0;
            lo_r      <= '0;
            done_r    <= 1'b0;
            divzero_r <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            cnt_r     <= cnt_nx_s;
            pend_r    <= pend_nx_s;
            hi_r      <= hi_nx_s;
            lo_r      <= lo_nx_s;
            done_r    <= done_nx_s;
            divzero_r <= divzero_nx_s;
        end
    end

    // Operand capture for the op being launched
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_r       <= MULT;
            a_r        <= '0;
            b_r        <= '0;
            dz_r       <= 1'b0;
            pend_op_r  <= MTHI;
            pend_val_r <= '0;
        end else begin
            if (latch_s) begin
                op_r <= op;
                a_r  <= a;
                b_r  <= b;
                dz_r <= (b == '0);
            end
            if (pend_nx_s) begin
                pend_op_r  <= op;
                pend_val_r <= a;
            end
        end
    end

    assign busy    = (state_r != ST_IDLE);
    assign done    = done_r;
    assign divzero = divzero_r;
    assign hi      = hi_r;
    assign lo      = lo_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus random ops checked
// against a plain-arithmetic HI/LO model.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W  = 32;
    localparam int ML = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         flush;
    muldiv_op_t   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic         divzero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] m_hi = 32'h0;
    logic [W-1:0] m_lo = 32'h0;
    muldiv_op_t ops [10];

    muldiv_unit #(.WIDTH(W), .MUL_LAT(ML)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .flush(flush),
        .busy(busy), .done(done), .divzero(divzero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: updates m_hi/m_lo and returns latency, busy-cycle count and flag.
    task automatic model(input muldiv_op_t o, input logic [31:0] x, input logic [31:0] y,
                         output int lat, output int bsy, output logic dz);
        logic [63:0] p;
        logic [63:0] qv;
        logic [63:0] rv;
        longint sx;
        longint sy;
        dz = 1'b0;
        case (o)
            MULT: begin
                p = {{32{x[31]}}, x} * {{32{y[31]}}, y};
                {m_hi, m_lo} = p; lat = ML; bsy = ML;
            end
            MULTU: begin
                p = {32'd0, x} * {32'd0, y};
                {m_hi, m_lo} = p; lat = ML; bsy = ML;
            end
            DIV, DIVU: begin
                if (y == 32'd0) begin
                    dz = 1'b1; m_lo = 32'hFFFF_FFFF; m_hi = x; lat = 2; bsy = 2;
                end else begin
                    if (o == DIV) begin
                        sx = $signed(x); sy = $signed(y);
                        qv = sx / sy; rv = sx % sy;
                        m_lo = qv[31:0]; m_hi = rv[31:0];
                    end else begin
                        m_lo = x / y; m_hi = x % y;
                    end
                    lat = W + 1; bsy = W + 1;
                end
            end
            MTHI: begin m_hi = x; lat = 1; bsy = 0; end
            MTLO: begin m_lo = x; lat = 1; bsy = 0; end
            default: begin
`ifdef MULDIV_MADD_EN
                if (o == MADD || o == MSUB) p = {{32{x[31]}}, x} * {{32{y[31]}}, y};
                else p = {32'd0, x} * {32'd0, y};
                if (o == MADD || o == MADDU) {m_hi, m_lo} = {m_hi, m_lo} + p;
                else {m_hi, m_lo} = {m_hi, m_lo} - p;
                lat = ML; bsy = ML;
`else
                lat = 1; bsy = 0;
`endif
            end
        endcase
    endtask

    task automatic run_op(input muldiv_op_t o, input logic [31:0] x, input logic [31:0] y, input string tag);
        int lat, bsy, n, bc;
        logic dz;
        model(o, x, y, lat, bsy, dz);
        @(negedge clk);
        start = 1'b1; flush = 1'b0; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0; bc = 0;
        while (done !== 1'b1 && n < 200) begin
            if (busy === 1'b1) bc++;
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_lat"}, 64'(n), 64'(lat));
        check({tag, "_busycyc"}, 64'(bc), 64'(bsy));
        check({tag, "_busy_at_done"}, 64'(busy), 64'(0));
        check({tag, "_hi"}, 64'(hi), 64'(m_hi));
        check({tag, "_lo"}, 64'(lo), 64'(m_lo));
        check({tag, "_divzero"}, 64'(divzero), 64'(dz));
    endtask

    function automatic logic [31:0] rnd_val();
        int unsigned k = $urandom_range(0, 7);
        case (k)
            0: return 32'h0000_0000;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'h0000_0001;
            default: return $urandom();
        endcase
    endfunction

    initial begin
        int dc;
        rst = 1'b1; start = 1'b0; flush = 1'b0; op = MULT; a = 32'h0; b = 32'h0;
        ops = '{MULT, MULTU, DIV, DIVU, MADD, MADDU, MSUB, MSUBU, MTHI, MTLO};
        repeat (3) @(posedge clk);
        #1;
        check("rst_hi", 64'(hi), 64'(0));
        check("rst_lo", 64'(lo), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_divzero", 64'(divzero), 64'(0));
        @(negedge clk); rst = 1'b0;

        run_op(MULT, 32'hFFFF_FFFD, 32'd5, "mult");
        check("mult_hi_k", 64'(hi), 64'h0000_0000_FFFF_FFFF);
        check("mult_lo_k", 64'(lo), 64'h0000_0000_FFFF_FFF1);
        run_op(MULTU, 32'hFFFF_FFFD, 32'd5, "multu");
        check("multu_hi_k", 64'(hi), 64'h0000_0000_0000_0004);
        run_op(DIVU, 32'd100, 32'd7, "divu");
        check("divu_lo_k", 64'(lo), 64'd14);
        check("divu_hi_k", 64'(hi), 64'd2);
        run_op(DIV, 32'hFFFF_FFF9, 32'd2, "div_neg");
        check("div_neg_lo_k", 64'(lo), 64'h0000_0000_FFFF_FFFD);
        check("div_neg_hi_k", 64'(hi), 64'h0000_0000_FFFF_FFFF);
        run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_min");
        check("div_min_lo_k", 64'(lo), 64'h0000_0000_8000_0000);
        check("div_min_hi_k", 64'(hi), 64'd0);
        run_op(DIVU, 32'h0000_1234, 32'd0, "divz");
        check("divz_flag_k", 64'(divzero), 64'd1);
        check("divz_lo_k", 64'(lo), 64'h0000_0000_FFFF_FFFF);
        check("divz_hi_k", 64'(hi), 64'h0000_0000_0000_1234);

        run_op(MTHI, 32'h0, 32'h0, "mthi");
        run_op(MTLO, 32'h10, 32'h0, "mtlo");
        run_op(MADD, 32'd3, 32'd4, "madd");
`ifdef MULDIV_MADD_EN
        check("madd_lo_k", 64'(lo), 64'h1C);
        run_op(MSUBU, 32'h20, 32'd1, "msubu");
        check("msubu_hi_k", 64'(hi), 64'h0000_0000_FFFF_FFFF);
        check("msubu_lo_k", 64'(lo), 64'h0000_0000_FFFF_FFFC);
`else
        check("madd_nop_lo_k", 64'(lo), 64'h10);
`endif

        // flush in the middle of a divide
        @(negedge clk); start = 1'b1; op = DIV; a = 32'd1000; b = 32'd3;
        @(posedge clk); #1; start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk); flush = 1'b1;
        @(posedge clk); #1;
        check("flush_div_busy", 64'(busy), 64'd0);
        check("flush_div_done", 64'(done), 64'd0);
        check("flush_div_hi", 64'(hi), 64'(m_hi));
        check("flush_div_lo", 64'(lo), 64'(m_lo));
        run_op(MULT, 32'd7, 32'hFFFF_FFFA, "after_flush");

        // flush together with start: not accepted
        @(negedge clk); start = 1'b1; flush = 1'b1; op = MTHI; a = 32'hDEAD_BEEF;
        @(posedge clk); #1; start = 1'b0; flush = 1'b0;
        check("flushstart_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        check("flushstart_done", 64'(done), 64'd0);
        check("flushstart_hi", 64'(hi), 64'(m_hi));

        // flush in the multiply completion cycle suppresses the write
        @(negedge clk); start = 1'b1; op = MULT; a = 32'd12345; b = 32'd678;
        @(posedge clk); #1; start = 1'b0;
        repeat (ML - 1) @(posedge clk);
        @(negedge clk); flush = 1'b1;
        @(posedge clk); #1;
        check("flushcmp_done", 64'(done), 64'd0);
        check("flushcmp_busy", 64'(busy), 64'd0);
        check("flushcmp_lo", 64'(lo), 64'(m_lo));
        check("flushcmp_hi", 64'(hi), 64'(m_hi));

        for (int i = 0; i < 40; i++) begin
            run_op(ops[$urandom_range(0, 9)], rnd_val(), rnd_val(), $sformatf("rnd%0d", i));
        end

        // reset in the middle of a divide discards it
        @(negedge clk); start = 1'b1; op = DIVU; a = 32'hFFFF_0000; b = 32'd9;
        @(posedge clk); #1; start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk); rst = 1'b1; #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_hi", 64'(hi), 64'd0);
        check("midrst_lo", 64'(lo), 64'd0);
        m_hi = 32'h0; m_lo = 32'h0;
        @(negedge clk); rst = 1'b0;
        dc = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) dc++;
        end
        check("midrst_nodone", 64'(dc), 64'd0);
        run_op(MTLO, 32'h5A5A_0001, 32'h0, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
